// File: rtl/pcap_pkg.sv
// Shared constants and width helpers for the pcount_capture timestamp stage.
// PCAP_TIMESTAMP_EXT_EN selects whether the wrap-extension field is part of each snapshot.
package pcap_pkg;

  localparam int DEF_WIDTH = 6;
  localparam int DEF_EXT_W = 4;
  localparam int DEF_DEPTH = 4;

`ifdef PCAP_TIMESTAMP_EXT_EN
  localparam bit EXT_EN = 1'b1;
`else
  localparam bit EXT_EN = 1'b0;
`endif

  // Snapshot width: raw count, optionally prefixed by the extension field.
  function automatic int snap_w(input int width, input int ext_w, input bit ext_en);
    return ext_en ? width + ext_w : width;
  endfunction

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/pcap_if.sv
// Consumer-side stream of pcount_capture snapshots.
// Handshake: data_o is accepted on a clock edge where valid_o && ready_i; valid_o never depends on ready_i.
interface pcap_if #(
    parameter int DW = 10
);
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          ready_i;

    modport master (output data_o, output valid_o, input ready_i);
    modport slave  (input data_o, input valid_o, output ready_i);
endinterface

// File: rtl/pcap_fifo.sv
// Synchronous FIFO with a registered head, full/empty flags and push+pop while full.
// The caller guarantees push only when not full or popping, and pop only when valid.
module pcap_fifo
    import pcap_pkg::*;
#(
    parameter int DW    = 10,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] data_o,
    output logic          valid_o,
    output logic          full_o
);
    localparam int PW = ptr_w(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [PW:0]   count, cnt_after_pop, cnt_nxt;
    logic [DW-1:0] head_nxt;

    // The head register is loaded with whatever will sit at the read pointer next cycle.
    always_comb begin
        rd_nxt        = rd_ptr + PW'(pop_i);
        cnt_after_pop = count - (PW+1)'(pop_i);
        cnt_nxt       = cnt_after_pop + (PW+1)'(push_i);
        head_nxt      = data_o;
        if (cnt_after_pop == '0) begin
            if (push_i) head_nxt = wdata_i;
        end else begin
            head_nxt = mem[rd_nxt];
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem[wr_ptr] <= wdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            data_o  <= '0;
            valid_o <= 1'b0;
            full_o  <= 1'b0;
        end else begin
            if (push_i) wr_ptr <= wr_ptr + 1'b1;
            rd_ptr  <= rd_nxt;
            count   <= cnt_nxt;
            data_o  <= head_nxt;
            valid_o <= (cnt_nxt != '0);
            full_o  <= (cnt_nxt == (PW+1)'(DEPTH));
        end
    end
endmodule

// File: rtl/pcount_capture.sv
// Timestamp capture behind pcounter: wrap extension, trigger snapshots, FIFO and sticky overflow.
// Define PCAP_TIMESTAMP_EXT_EN to build the wrap-extension field into each snapshot.
module pcount_capture
    import pcap_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int EXT_W = DEF_EXT_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] count_i,
    input  logic             trig_i,
    pcap_if.master           cons,
    output logic             full_o,
    output logic             ovf_o,
    input  logic             clr_ovf_i
);
    localparam int DW = snap_w(WIDTH, EXT_W, EXT_EN);

    logic [DW-1:0] snap;
    logic          pop, push, drop, valid;

`ifdef PCAP_TIMESTAMP_EXT_EN
    logic [WIDTH-1:0] prev_cnt;
    logic [EXT_W-1:0] ext, ext_next;
    logic             wrap;

    // A trigger coinciding with the wrap already carries the post-wrap extension.
    assign wrap     = en_i && (prev_cnt == '1) && (count_i == '0);
    assign ext_next = ext + EXT_W'(wrap);
    assign snap     = {ext_next, count_i};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_cnt <= '0;
            ext      <= '0;
        end else begin
            prev_cnt <= count_i;
            ext      <= ext_next;
        end
    end
`else
    logic unused_en;
    assign unused_en = en_i;
    assign snap      = count_i;
`endif

    assign pop  = valid && cons.ready_i;
    assign push = trig_i && (!full_o || pop);
    assign drop = trig_i && full_o && !pop;

    // A clear wins over a drop in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i)          ovf_o <= 1'b0;
        else if (clr_ovf_i) ovf_o <= 1'b0;
        else if (drop)      ovf_o <= 1'b1;
    end

    pcap_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (snap),
        .data_o  (cons.data_o),
        .valid_o (valid),
        .full_o  (full_o)
    );

    assign cons.valid_o = valid;
endmodule
